// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared types and constants for the sequential packed-BCD to binary converter.
package bcd_to_bin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned     BCD_DIGIT_W = 4;
  localparam logic [3:0]      BCD_MAX     = 4'd9;

endpackage

// File: rtl/bcd_to_bin_seq_mul10_add.sv
// bcd_mul10_add: combinational acc*10 + digit step with a digit range flag.
// Optional feature macro: BCD_TO_BIN_ERR_CHK_EN (digit range check; when
// undefined the comparator is removed and digit_invalid is constant 0).
module bcd_mul10_add
  import bcd_to_bin_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic [BIN_W-1:0]       acc,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BIN_W-1:0]       acc_out,
  output logic                   digit_invalid
);

  logic [BIN_W-1:0] w_x8;
  logic [BIN_W-1:0] w_x2;

  // Multiply by ten as shift-and-add, truncated to BIN_W, then add the digit.
  always_comb begin
    w_x8    = acc << 3;
    w_x2    = acc << 1;
    acc_out = w_x8 + w_x2 + BIN_W'(digit);
  end

`ifdef BCD_TO_BIN_ERR_CHK_EN
  assign digit_invalid = (digit > BCD_MAX);
`else
  assign digit_invalid = 1'b0;
`endif

endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: converts one packed-BCD word per start pulse into binary,
// one digit per clock, most significant digit first.
// Optional feature macro: BCD_TO_BIN_ERR_CHK_EN (enables digit range
// checking; without it err stays 0 and bin_out is the raw accumulation).
module bcd_to_bin_seq
  import bcd_to_bin_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          busy,
  output logic                          done,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          err
);

  localparam int unsigned SR_W  = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [SR_W-1:0]          r_shift;
  logic [BIN_W-1:0]         r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_err_flag;
  logic                     r_busy;
  logic                     r_done;
  logic [BIN_W-1:0]         r_bin_out;
  logic                     r_err;
  logic [BIN_W-1:0]         w_acc_nxt;
  logic                     w_dig_inv;
  logic [BCD_DIGIT_W-1:0]   w_digit;

  assign w_digit = r_shift[SR_W-1 -: BCD_DIGIT_W];

  bcd_mul10_add #(
    .BIN_W(BIN_W)
  ) u_mul10_add (
    .acc          (r_acc),
    .digit        (w_digit),
    .acc_out      (w_acc_nxt),
    .digit_invalid(w_dig_inv)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> CONV -> DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_CONV;
      ST_CONV: if (r_cnt == '0) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; done/bin_out/err update on the edge leaving DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_err_flag <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bin_out  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_state_nxt != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shift    <= bcd_in;
            r_acc      <= '0;
            r_err_flag <= 1'b0;
            r_cnt      <= CNT_W'(DIGITS - 1);
          end
        end
        ST_CONV: begin
          r_acc   <= w_acc_nxt;
          r_shift <= r_shift << BCD_DIGIT_W;
          if (w_dig_inv) r_err_flag <= 1'b1;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        ST_DONE: begin
          r_done    <= 1'b1;
          r_bin_out <= r_err_flag ? '0 : r_acc;
          r_err     <= r_err_flag;
        end
        default: ;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign bin_out = r_bin_out;
  assign err     = r_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq (DIGITS=4, BIN_W=14).
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bcd_in = '0;
  logic        busy;
  logic        done;
  logic [13:0] bin_out;
  logic        err;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned cyc    = 0;

  typedef struct {
    logic [13:0] bin;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];

  bcd_to_bin_seq #(
    .DIGITS(4),
    .BIN_W (14)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bcd_in (bcd_in),
    .busy   (busy),
    .done   (done),
    .bin_out(bin_out),
    .err    (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done) begin
      n_chk = n_chk + 1;
      if (sb.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_done: bin_out=%0d err=%0b cyc=%0d, required no done", bin_out, err, cyc);
      end else begin
        e = sb.pop_front();
        if (bin_out !== e.bin || err !== e.err || cyc != e.cyc)
          begin
            n_fail = n_fail + 1;
            $display("FAIL result: bin_out=%0d err=%0b cyc=%0d, required bin_out=%0d err=%0b cyc=%0d",
                     bin_out, err, cyc, e.bin, e.err, e.cyc);
          end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk = n_chk + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [13:0] b, input logic e, input int unsigned c);
    exp_t x;
    x.bin = b; x.err = e; x.cyc = c;
    sb.push_back(x);
  endtask

  // Issue one conversion from IDLE and wait (bounded) for its done pulse.
  task automatic run(input logic [15:0] v, input logic [13:0] eb, input logic ee,
                     output int unsigned busy_cycles);
    bit seen;
    busy_cycles = 0;
    seen = 0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = v;
    push_exp(eb, ee, cyc + 6);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (busy) busy_cycles++;
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic wait_done(input int unsigned n);
    int unsigned got;
    got = 0;
    for (int k = 0; k < 60 && got < n; k++) begin
      @(negedge clk);
      if (done) got++;
    end
    if (got < n) check("done_timeout", got, n);
  endtask

  initial begin
    int unsigned bc;
    int unsigned got;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_bin_out", 32'(bin_out), 0);
    check("rst_err", 32'(err), 0);

    run(16'h0000, 14'd0, 1'b0, bc);

    run(16'h9999, 14'd9999, 1'b0, bc);
    check("busy_cycles_9999", bc, 5);

    // Second start two cycles later lands in CONV and must be ignored.
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h1234;
    push_exp(14'd1234, 1'b0, cyc + 6);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h5678;
    @(negedge clk);
    start = 1'b0;
    wait_done(1);
    repeat (8) @(negedge clk);
    run(16'h5678, 14'd5678, 1'b0, bc);

`ifdef BCD_TO_BIN_ERR_CHK_EN
    run(16'h12A4, 14'd0, 1'b1, bc);
`else
    run(16'h12A4, 14'd1304, 1'b0, bc);
`endif

    run(16'h0001, 14'd1, 1'b0, bc);

    // Reset during CONV: no done, outputs cleared.
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0042;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_bin_out", 32'(bin_out), 0);
    check("midrst_err", 32'(err), 0);
    repeat (8) @(negedge clk);
    run(16'h0042, 14'd42, 1'b0, bc);

    // Held start: accepted every DIGITS+2 = 6 cycles.
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0007;
    push_exp(14'd7, 1'b0, cyc + 6);
    push_exp(14'd7, 1'b0, cyc + 12);
    push_exp(14'd7, 1'b0, cyc + 18);
    got = 0;
    for (int k = 0; k < 40 && got < 2; k++) begin
      @(negedge clk);
      if (done) got++;
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(1);
    repeat (10) @(negedge clk);

    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential multi-digit packed-BCD to binary converter; the decode direction for BCD data produced by the BCD adder datapath.
- Accepts one packed BCD word per start pulse.
- Processes one digit per clock, most significant digit first: acc = acc*10 + digit.
- Returns the binary value with a one-cycle done pulse and a digit-error flag.
- Sits between BCD arithmetic/display logic and binary consumers such as counters and comparators.

Parameters:
DIGITS, 4, number of BCD digits in bcd_in (1..8)
BIN_W, 14, binary output width; must be >= ceil(log2(10^DIGITS)) (14 for 4 digits)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request conversion; sampled only in IDLE
bcd_in  input  4*DIGITS  packed BCD, digit DIGITS-1 in MSBs; captured on accepted start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, result valid
bin_out  output  BIN_W  binary result; updated only with done, held otherwise
err  output  1  valid with done; high if any digit > 9; held with bin_out

Behaviour:
- Clocking and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, bin_out=0, err=0, accumulator=0, digit counter=0.
- States: IDLE -> CONV -> DONE -> IDLE.
- IDLE:
  - On start=1, capture bcd_in into a shift register, clear the accumulator and error flag, set counter=DIGITS-1, go to CONV.
  - start=0 stays in IDLE.
- CONV, each cycle:
  - acc <= acc*10 + d, where d = top digit of the shift register; shift the register left 4 bits.
  - If d > 9, set the sticky error flag.
  - If counter==0, go to DONE; else decrement the counter.
- DONE, one cycle:
  - done=1; bin_out <= acc (or 0 if the error flag is set); err <= error flag; next state IDLE.
- Latency: done is high in the cycle after DIGITS+1 rising edges following the edge that sampled start. For DIGITS=4, done is seen 6 edges after the start edge, counting the start edge as edge 1.
- Back-to-back: start may be asserted in the cycle done is high, but it is ignored because state=DONE (busy=1). The next accepted start is in IDLE, so minimum issue interval is DIGITS+2 cycles.
- start while busy: ignored; bcd_in is not re-captured.
- Arithmetic:
  - acc*10 is computed as (acc<<3)+(acc<<1), truncated to BIN_W.
  - No overflow is possible when BIN_W meets the parameter rule.
  - Digits 10..15 are still accumulated raw; the result is replaced by 0 at DONE.
- Reset mid-conversion: return to IDLE next edge, no done pulse, bin_out/err cleared to 0.
- done, busy, bin_out and err are registered outputs; no combinational path from start or bcd_in.

Optional Feature:
BCD_TO_BIN_ERR_CHK_EN
- Defined: digit-range checking as specified; err reports invalid digits and bin_out is forced to 0 on error.
- Undefined: the check logic is removed, err is tied 0, and bin_out always equals the raw acc*10+d accumulation.

Decomposition:
- Package bcd_to_bin_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_CONV=2'd1, ST_DONE=2'd2;
  - BCD_DIGIT_W=4;
  - BCD_MAX=4'd9.
- One sub-module, bcd_mul10_add: combinational, inputs acc[BIN_W] and digit[4]; outputs acc*10+digit and a digit_invalid flag. The top level holds the FSM, counter, shift register and output registers.

Test Plan:
- Reset, then start with bcd_in=16'h0000 -> done after 6 edges, bin_out=0, err=0.
- start with bcd_in=16'h9999 -> bin_out=14'd9999 (0x270F), err=0; busy high for 5 cycles.
- start with bcd_in=16'h1234, re-pulse start with 16'h5678 two cycles later -> second start ignored; bin_out=1234; then issue 16'h5678 from IDLE -> bin_out=5678.
- start with bcd_in=16'h12A4 -> err=1, bin_out=0 (with BCD_TO_BIN_ERR_CHK_EN); without the macro, err=0 and bin_out=1304.
- start with 16'h0042, assert rst for one cycle during CONV -> no done, busy=0, bin_out=0 next cycle; a following conversion of 16'h0042 -> bin_out=42.
- Hold start=1 continuously with 16'h0007 -> conversions at a period of DIGITS+2=6 cycles, each done pulse one cycle wide with bin_out=7.
